// File: rtl/spi_ram_burst_if.sv
// spi_ram_burst_if: command stream in, read data out, plus error pulse for spi_ram_burst
interface spi_ram_burst_if #(parameter int MEM_WIDTH = 8, parameter int ADDR_SIZE = 8);
  localparam int PW = ADDR_SIZE > MEM_WIDTH ? ADDR_SIZE : MEM_WIDTH;
  logic [PW+1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic [MEM_WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic err;
  modport master(output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid, err);
  modport slave(input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid, err);
endinterface

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-driven RAM with registered single-word reads; define RAM_AUTO_INC_EN for address auto-increment
module spi_ram_burst #(
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 2**ADDR_SIZE
) (
  input logic clk,
  input logic rst,
  spi_ram_burst_if.slave bus
);
  localparam int PW = ADDR_SIZE > MEM_WIDTH ? ADDR_SIZE : MEM_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, RD_FETCH = 2'd1, RD_HOLD = 2'd2;
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);
  logic [1:0] r_state;
  logic [ADDR_SIZE-1:0] r_wr_addr, r_rd_addr;
  logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] r_tx_data;
  logic r_err;
  logic w_acc, w_leave, w_addr_bad, w_wr_bad, w_rd_bad, w_wr_inc, w_rd_inc;
  logic [1:0] w_cmd;
  logic [ADDR_SIZE-1:0] w_addr, w_wr_nxt, w_rd_nxt;
  assign w_cmd = bus.rx_data[PW+1:PW];
  assign w_addr = bus.rx_data[ADDR_SIZE-1:0];
  assign w_acc = bus.rx_valid && bus.rx_ready;
  assign w_leave = r_state == RD_HOLD && bus.tx_ready;
  assign w_addr_bad = {1'b0, w_addr} >= DEPTH;
  assign w_wr_bad = {1'b0, r_wr_addr} >= DEPTH;
  assign w_rd_bad = {1'b0, r_rd_addr} >= DEPTH;
  assign w_wr_nxt = r_wr_addr == LAST ? '0 : r_wr_addr + 1'b1;
  assign w_rd_nxt = r_rd_addr == LAST ? '0 : r_rd_addr + 1'b1;
`ifdef RAM_AUTO_INC_EN
  assign w_wr_inc = w_acc && w_cmd == 2'b01;
  assign w_rd_inc = w_leave;
`else
  assign w_wr_inc = 1'b0;
  assign w_rd_inc = 1'b0;
`endif
  assign bus.rx_ready = r_state == IDLE && !rst;
  assign bus.tx_valid = r_state == RD_HOLD;
  assign bus.tx_data = r_tx_data;
  assign bus.err = r_err;
  // read FSM: a single word is fetched, then held until the consumer takes it
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= r_state == IDLE ? (w_acc && w_cmd == 2'b11 ? RD_FETCH : IDLE) :
                    r_state == RD_FETCH ? RD_HOLD :
                    r_state == RD_HOLD && !bus.tx_ready ? RD_HOLD : IDLE;
  // address pointers: loaded by commands 00/10, optionally stepped after each use
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else begin
      r_wr_addr <= w_acc && w_cmd == 2'b00 ? w_addr : w_wr_inc ? w_wr_nxt : r_wr_addr;
      r_rd_addr <= w_acc && w_cmd == 2'b10 ? w_addr : w_rd_inc ? w_rd_nxt : r_rd_addr;
    end
  // storage: cleared on reset, written only through an in-range write pointer
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_acc && w_cmd == 2'b01 && !w_wr_bad) r_mem[r_wr_addr] <= bus.rx_data[MEM_WIDTH-1:0];
  // registered fetch; an out-of-range read address returns zero
  always_ff @(posedge clk)
    if (rst) r_tx_data <= '0;
    else if (r_state == RD_FETCH) r_tx_data <= w_rd_bad ? '0 : r_mem[r_rd_addr];
  // one-cycle error pulse for any accepted command touching an out-of-range address
  always_ff @(posedge clk)
    if (rst) r_err <= 1'b0;
    else r_err <= w_acc && (w_cmd == 2'b01 ? w_wr_bad : w_cmd == 2'b11 ? w_rd_bad : w_addr_bad);
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: random command stream against an array model of the RAM with MEM_DEPTH=200
module tb_spi_ram_burst;
  localparam int DEPTH = 200;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int m_mem [256];
  int m_wr = 0;
  int m_rd = 0;
  spi_ram_burst_if #(.MEM_WIDTH(8), .ADDR_SIZE(8)) bus ();
  spi_ram_burst #(.MEM_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    m_wr = 0;
    m_rd = 0;
  endtask
  task automatic read_tail();
    int exp;
    int n;
    exp = m_rd >= DEPTH ? 0 : m_mem[m_rd];
    chk("fetch_tx_valid", 32'(bus.tx_valid), 0);
    chk("fetch_rx_ready", 32'(bus.rx_ready), 0);
    bus.rx_data = {2'b00, 8'h10};
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    chk("hold_tx_valid", 32'(bus.tx_valid), 1);
    chk("hold_tx_data", 32'(bus.tx_data), 32'(exp));
    chk("hold_err", 32'(bus.err), 0);
    n = $urandom_range(0, 5);
    repeat (n) begin
      step();
      chk("stall_tx_valid", 32'(bus.tx_valid), 1);
      chk("stall_tx_data", 32'(bus.tx_data), 32'(exp));
      chk("stall_rx_ready", 32'(bus.rx_ready), 0);
    end
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    chk("done_tx_valid", 32'(bus.tx_valid), 0);
    chk("done_rx_ready", 32'(bus.rx_ready), 1);
`ifdef RAM_AUTO_INC_EN
    m_rd = m_rd == DEPTH - 1 ? 0 : (m_rd + 1) % 256;
`endif
  endtask
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] p);
    bit e;
    chk("accept_rx_ready", 32'(bus.rx_ready), 1);
    bus.rx_data = {c, p};
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    e = 0;
    if (c == 2'b00) begin
      e = p >= DEPTH;
      m_wr = p;
    end else if (c == 2'b01) begin
      e = m_wr >= DEPTH;
      if (!e) m_mem[m_wr] = p;
`ifdef RAM_AUTO_INC_EN
      m_wr = m_wr == DEPTH - 1 ? 0 : (m_wr + 1) % 256;
`endif
    end else if (c == 2'b10) begin
      e = p >= DEPTH;
      m_rd = p;
    end else e = m_rd >= DEPTH;
    chk("err", 32'(bus.err), 32'(e));
    if (c == 2'b11) read_tail();
    else begin
      step();
      chk("err_pulse", 32'(bus.err), 0);
    end
  endtask
  initial begin
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_rx_ready", 32'(bus.rx_ready), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst = 1'b0;
    step();
    do_cmd(2'b00, 8'h05);
    do_cmd(2'b01, 8'hA5);
    do_cmd(2'b10, 8'h05);
    do_cmd(2'b11, 8'h00);
    do_cmd(2'b00, 8'hC8);
    do_cmd(2'b01, 8'h33);
    do_cmd(2'b10, 8'hC8);
    do_cmd(2'b11, 8'h00);
    do_cmd(2'b00, 8'(DEPTH - 1));
    do_cmd(2'b01, 8'h11);
    do_cmd(2'b01, 8'h22);
    do_cmd(2'b10, 8'(DEPTH - 1));
    do_cmd(2'b11, 8'h00);
    do_cmd(2'b11, 8'h00);
    do_cmd(2'b10, 8'h00);
    do_cmd(2'b11, 8'h00);
    for (int i = 0; i < 400; i++) do_cmd(2'($urandom_range(0, 3)), 8'($urandom));
    do_cmd(2'b00, 8'h07);
    do_cmd(2'b01, 8'h5A);
    do_cmd(2'b10, 8'h07);
    bus.rx_data = {2'b11, 8'h00};
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    step();
    chk("pre_rst_tx_valid", 32'(bus.tx_valid), 1);
    chk("pre_rst_tx_data", 32'(bus.tx_data), 32'h5A);
    rst = 1'b1;
    step();
    chk("abort_tx_valid", 32'(bus.tx_valid), 0);
    chk("abort_rx_ready", 32'(bus.rx_ready), 0);
    chk("abort_tx_data", 32'(bus.tx_data), 0);
    chk("abort_err", 32'(bus.err), 0);
    rst = 1'b0;
    model_reset();
    step();
    chk("post_rst_tx_valid", 32'(bus.tx_valid), 0);
    do_cmd(2'b10, 8'h07);
    do_cmd(2'b11, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
